// File: rtl/galvo_axis_sequencer.sv
// Per-axis galvo sequencer: waits for a stable home indication, then issues
// scaled setpoints from the latest received frame whenever the motor is idle.
module galvo_axis_sequencer #(
    parameter int NUM_AXES   = 2,
    parameter int POS_W      = 16,
    parameter int SHIFT      = 5,
    parameter int OFFSET     = 1024,
    parameter int SETTLE_CYC = 50_000_000,
    parameter int LOSS_CYC   = 50_000_000,
    parameter int VEL_W      = 16,
    parameter int VEL_RST    = 136
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [NUM_AXES-1:0]       home_n,
    input  logic                      rec_valid,
    input  logic [NUM_AXES*POS_W-1:0] rec_pos,
    input  logic [NUM_AXES-1:0]       m_busy,
    input  logic                      vel_wr,
    input  logic [VEL_W-1:0]          vel_in,
    output logic [NUM_AXES*POS_W-1:0] set_pos,
    output logic [NUM_AXES-1:0]       set_pos_valid,
    output logic [NUM_AXES-1:0]       axis_ready,
    output logic [VEL_W-1:0]          set_vel
);

    localparam int MAX_CYC = (SETTLE_CYC > LOSS_CYC) ? SETTLE_CYC : LOSS_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [POS_W-1:0] OFFSET_W    = POS_W'(OFFSET);

    typedef enum logic [1:0] {
        WAIT_HOME = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state_q   [NUM_AXES];
    state_t             state_d   [NUM_AXES];
    logic [CNT_W-1:0]   settle_q  [NUM_AXES];
    logic [CNT_W-1:0]   settle_d  [NUM_AXES];
    logic [CNT_W-1:0]   loss_q    [NUM_AXES];
    logic [CNT_W-1:0]   loss_d    [NUM_AXES];
    logic [POS_W-1:0]   pend_q    [NUM_AXES];
    logic [POS_W-1:0]   pend_d    [NUM_AXES];
    logic [POS_W-1:0]   pos_q     [NUM_AXES];
    logic [POS_W-1:0]   pos_d     [NUM_AXES];
    logic [NUM_AXES-1:0] pending_q, pending_d;
    logic [NUM_AXES-1:0] vld_q, vld_d;
    logic [VEL_W-1:0]    vel_q;

    // Wraps modulo 2^POS_W by truncation of the sum.
    function automatic logic [POS_W-1:0] scale_pos(input logic [POS_W-1:0] p);
        return (p >> SHIFT) + OFFSET_W;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_AXES; i++) begin
            state_d[i]   = state_q[i];
            settle_d[i]  = settle_q[i];
            loss_d[i]    = loss_q[i];
            pend_d[i]    = pend_q[i];
            pos_d[i]     = pos_q[i];
            pending_d[i] = pending_q[i];
            vld_d[i]     = 1'b0;

            // Loss counter saturates so a long-absent home never wraps back to zero.
            if (!home_n[i]) begin
                loss_d[i] = '0;
            end else if (loss_q[i] != LOSS_LAST) begin
                loss_d[i] = loss_q[i] + CNT_ONE;
            end

            if ((state_q[i] == RUN) && pending_q[i] && !m_busy[i]) begin
                pos_d[i]     = scale_pos(pend_q[i]);
                vld_d[i]     = 1'b1;
                pending_d[i] = 1'b0;
            end

            // A frame arriving alongside an issue stays pending for the next one.
            if (rec_valid) begin
                pend_d[i]    = rec_pos[i*POS_W +: POS_W];
                pending_d[i] = 1'b1;
            end

            case (state_q[i])
                WAIT_HOME: begin
                    if (!home_n[i]) begin
                        state_d[i]  = SETTLE;
                        settle_d[i] = '0;
                    end
                end
                SETTLE: begin
                    if (!home_n[i]) begin
                        if (settle_q[i] == SETTLE_LAST) begin
                            state_d[i] = RUN;
                        end else begin
                            settle_d[i] = settle_q[i] + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase

            if ((state_q[i] != WAIT_HOME) && home_n[i] && (loss_q[i] == LOSS_LAST)) begin
                state_d[i]   = WAIT_HOME;
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AXES; i++) begin
                state_q[i]  <= WAIT_HOME;
                settle_q[i] <= '0;
                loss_q[i]   <= '0;
                pend_q[i]   <= '0;
                pos_q[i]    <= '0;
            end
            pending_q <= '0;
            vld_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_AXES; i++) begin
                state_q[i]  <= state_d[i];
                settle_q[i] <= settle_d[i];
                loss_q[i]   <= loss_d[i];
                pend_q[i]   <= pend_d[i];
                pos_q[i]    <= pos_d[i];
            end
            pending_q <= pending_d;
            vld_q     <= vld_d;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vel_q <= VEL_W'(VEL_RST);
        end else if (vel_wr) begin
            vel_q <= vel_in;
        end
    end

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_out
        assign set_pos[g*POS_W +: POS_W] = pos_q[g];
        assign axis_ready[g]             = (state_q[g] == RUN);
    end

    assign set_pos_valid = vld_q;
    assign set_vel       = vel_q;

endmodule

// File: tb/tb_galvo_axis_sequencer.sv
// Directed bench for galvo_axis_sequencer: settle/loss timing, setpoint issue
// table, offset wrap on a second instance, velocity register and async reset.
module tb_galvo_axis_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  home_n;
    logic        rec_valid;
    logic [31:0] rec_pos;
    logic [1:0]  m_busy;
    logic        vel_wr;
    logic [15:0] vel_in;
    logic [31:0] set_pos;
    logic [1:0]  set_pos_valid;
    logic [1:0]  axis_ready;
    logic [15:0] set_vel;

    logic        o_home_n, o_rec_valid, o_busy, o_valid, o_ready;
    logic [15:0] o_rec_pos, o_set_pos, o_set_vel;

    int n_checks = 0;
    int n_fail   = 0;

    galvo_axis_sequencer #(
        .NUM_AXES(2), .POS_W(16), .SHIFT(5), .OFFSET(1024),
        .SETTLE_CYC(100), .LOSS_CYC(50), .VEL_W(16), .VEL_RST(136)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .home_n(home_n), .rec_valid(rec_valid),
        .rec_pos(rec_pos), .m_busy(m_busy), .vel_wr(vel_wr), .vel_in(vel_in),
        .set_pos(set_pos), .set_pos_valid(set_pos_valid),
        .axis_ready(axis_ready), .set_vel(set_vel)
    );

    galvo_axis_sequencer #(
        .NUM_AXES(1), .POS_W(16), .SHIFT(5), .OFFSET(65500),
        .SETTLE_CYC(4), .LOSS_CYC(50), .VEL_W(16), .VEL_RST(136)
    ) u_off (
        .sys_clk(clk), .rst_n(rst_n), .home_n(o_home_n), .rec_valid(o_rec_valid),
        .rec_pos(o_rec_pos), .m_busy(o_busy), .vel_wr(1'b0), .vel_in(16'd0),
        .set_pos(o_set_pos), .set_pos_valid(o_valid),
        .axis_ready(o_ready), .set_vel(o_set_vel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic        rv;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [1:0]  busy;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  ev;
    } vec_t;

    vec_t tbl [8];
    int   v1_pulses;

    initial begin
        // rv, pos0, pos1, busy -> expected set_pos0, set_pos1, set_pos_valid after the edge
        tbl[0] = '{1'b1, 16'h8000, 16'h0040, 2'b00, 16'd0,    16'd0,    2'b00};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'd2048, 16'd1026, 2'b11};
        tbl[2] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'd2048, 16'd1026, 2'b00};
        tbl[3] = '{1'b1, 16'h0400, 16'h0000, 2'b01, 16'd2048, 16'd1026, 2'b00};
        tbl[4] = '{1'b1, 16'h0800, 16'h0020, 2'b01, 16'd2048, 16'd1024, 2'b10};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 2'b01, 16'd2048, 16'd1025, 2'b10};
        tbl[6] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'd1088, 16'd1025, 2'b01};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'd1088, 16'd1025, 2'b00};

        rst_n = 1'b0; home_n = 2'b11; rec_valid = 1'b0; rec_pos = '0;
        m_busy = 2'b00; vel_wr = 1'b0; vel_in = '0;
        o_home_n = 1'b0; o_rec_valid = 1'b0; o_rec_pos = '0; o_busy = 1'b0;
        step(3);
        check("rst_ready", 32'(axis_ready), 32'd0);
        check("rst_valid", 32'(set_pos_valid), 32'd0);
        check("rst_set_pos", set_pos, 32'd0);
        check("rst_set_vel", 32'(set_vel), 32'd136);

        // Settle: axis 1 clean, axis 0 with a 10-cycle home glitch
        home_n = 2'b00;
        rst_n  = 1'b1;
        step(20);
        home_n = 2'b01;
        step(10);
        home_n = 2'b00;
        step(70);
        check("ready_at_100", 32'(axis_ready), 32'd0);
        step(1);
        check("ready_at_101", 32'(axis_ready), 32'b10);
        step(9);
        check("ready_at_110", 32'(axis_ready), 32'b10);
        step(1);
        check("ready_at_111", 32'(axis_ready), 32'b11);

        for (int k = 0; k < 8; k++) begin
            rec_valid = tbl[k].rv;
            rec_pos   = {tbl[k].p1, tbl[k].p0};
            m_busy    = tbl[k].busy;
            step(1);
            check($sformatf("vec%0d_valid", k), 32'(set_pos_valid), 32'(tbl[k].ev));
            check($sformatf("vec%0d_pos0", k), 32'(set_pos[15:0]), 32'(tbl[k].e0));
            check($sformatf("vec%0d_pos1", k), 32'(set_pos[31:16]), 32'(tbl[k].e1));
        end
        rec_valid = 1'b0;

        // Home loss on axis 1 while a frame is pending behind a busy motor
        m_busy    = 2'b10;
        rec_valid = 1'b1;
        rec_pos   = {16'h0400, 16'h0800};
        step(1);
        rec_valid = 1'b0;
        home_n    = 2'b10;
        step(49);
        check("loss49_ready", 32'(axis_ready), 32'b11);
        home_n = 2'b00;
        step(1);
        check("loss_clear_ready", 32'(axis_ready), 32'b11);
        home_n = 2'b10;
        step(49);
        check("loss49b_ready", 32'(axis_ready), 32'b11);
        step(1);
        check("loss50_ready", 32'(axis_ready), 32'b01);
        check("loss50_pos1_held", 32'(set_pos[31:16]), 32'd1025);
        check("loss50_pos0", 32'(set_pos[15:0]), 32'd1088);

        home_n    = 2'b00;
        m_busy    = 2'b00;
        v1_pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (set_pos_valid[1]) v1_pulses++;
        end
        check("rearm_ready_100", 32'(axis_ready), 32'b01);
        step(1);
        check("rearm_ready_101", 32'(axis_ready), 32'b11);
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (set_pos_valid[1]) v1_pulses++;
        end
        check("pending_cleared_no_issue", 32'(v1_pulses), 32'd0);
        check("rearm_pos1_held", 32'(set_pos[31:16]), 32'd1025);

        // Velocity register
        check("vel_before_wr", 32'(set_vel), 32'd136);
        vel_wr = 1'b1;
        vel_in = 16'd34;
        step(1);
        vel_wr = 1'b0;
        vel_in = 16'd999;
        check("vel_written", 32'(set_vel), 32'd34);
        step(2);
        check("vel_held", 32'(set_vel), 32'd34);

        // Offset wrap on the second instance
        check("off_ready", 32'(o_ready), 32'd1);
        o_rec_valid = 1'b1;
        o_rec_pos   = 16'hFFFF;
        step(1);
        o_rec_valid = 1'b0;
        check("off_no_early_valid", 32'(o_valid), 32'd0);
        step(1);
        check("off_valid", 32'(o_valid), 32'd1);
        check("off_wrap_pos", 32'(o_set_pos), 32'd2011);

        // Asynchronous reset mid-RUN
        rec_valid = 1'b1;
        rec_pos   = {16'h0100, 16'h0200};
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(axis_ready), 32'd0);
        check("arst_valid", 32'(set_pos_valid), 32'd0);
        check("arst_set_pos", set_pos, 32'd0);
        check("arst_set_vel", 32'(set_vel), 32'd136);
        rec_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("release_valid", 32'(set_pos_valid), 32'd0);
        check("release_ready", 32'(axis_ready), 32'd0);
        check("release_set_pos", set_pos, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/galvo_axis_sequencer.md
GALVO_AXIS_SEQUENCER -- requirements
Module: galvo_axis_sequencer

Interface
REQ-001 SHALL have parameter NUM_AXES, default 2: number of independent axes (1..8).
REQ-002 SHALL have parameter POS_W, default 16: width of received and issued positions.
REQ-003 SHALL have parameter SHIFT, default 5: right-shift applied to received position.
REQ-004 SHALL have parameter OFFSET, default 1024: unsigned offset added after the shift.
REQ-005 SHALL have parameter SETTLE_CYC, default 50_000_000: cycles home must hold before an axis runs.
REQ-006 SHALL have parameter LOSS_CYC, default 50_000_000: cycles of continuous home loss that re-arm an axis.
REQ-007 SHALL have parameter VEL_W, default 16, and VEL_RST, default 136: velocity width and reset value.
REQ-008 SHALL have port sys_clk, input, 1: system clock, all logic on rising edge.
REQ-009 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port home_n, input, NUM_AXES: per-axis drive home-done, low = homed, already synchronised.
REQ-011 SHALL have port rec_valid, input, 1: one-cycle strobe, new frame on rec_pos.
REQ-012 SHALL have port rec_pos, input, NUM_AXES*POS_W: packed received positions, axis i at [i*POS_W +: POS_W].
REQ-013 SHALL have port m_busy, input, NUM_AXES: per-axis motor busy (pulses in progress).
REQ-014 SHALL have port vel_wr, input, 1, and vel_in, input, VEL_W: velocity write strobe and value.
REQ-015 SHALL have port set_pos, output, NUM_AXES*POS_W: packed registered setpoints.
REQ-016 SHALL have port set_pos_valid, output, NUM_AXES: one-cycle strobe per issued setpoint.
REQ-017 SHALL have port axis_ready, output, NUM_AXES: high while the axis is in RUN.
REQ-018 SHALL have port set_vel, output, VEL_W: registered shared velocity period.

Function
REQ-019 SHALL implement one independent FSM per axis with states WAIT_HOME, SETTLE, RUN.
REQ-020 WAIT_HOME -> SETTLE when home_n[i] is low; settle counter cleared on entry.
REQ-021 SETTLE: counter increments only on cycles with home_n[i] low; holds on high cycles; -> RUN on the cycle the counter reaches SETTLE_CYC-1 with home_n[i] low.
REQ-022 Loss counter per axis: increments while home_n[i] high, clears when low; in SETTLE or RUN, reaching LOSS_CYC-1 -> WAIT_HOME next cycle, pending flag cleared.
REQ-023 Home glitches shorter than LOSS_CYC cycles SHALL NOT change state.
REQ-024 On rec_valid, each axis captures its rec_pos slice into a pending register and sets pending, in any state; a later frame overwrites an unissued one (latest wins).
REQ-025 Issue: in RUN with pending set and m_busy[i] low, set_pos slice <= ((pend >> SHIFT) + OFFSET) mod 2^POS_W, set_pos_valid[i] pulses for exactly one cycle, and pending clears; latency one cycle from the qualifying condition.
REQ-026 If rec_valid coincides with an issue, the issue uses the old pending value and the new value remains pending.
REQ-027 set_pos slice SHALL hold its last issued value in every state, including after returning to WAIT_HOME.
REQ-028 Axes SHALL be fully independent; simultaneous issues on several axes allowed.
REQ-029 set_vel <= vel_in on vel_wr, otherwise holds.
REQ-030 Counters SHALL be sized $clog2(max(SETTLE_CYC,LOSS_CYC)+1) bits and SHALL never wrap.

Reset
REQ-031 During reset: all FSMs WAIT_HOME, counters 0, pending 0, set_pos 0, set_pos_valid 0, axis_ready 0, set_vel VEL_RST.
REQ-032 Reset asserted mid-operation SHALL abort immediately; no strobe in the reset-release cycle.

Verification (NUM_AXES=2, SHIFT=5, OFFSET=1024, SETTLE_CYC=100, LOSS_CYC=50)
REQ-033 home_n=2'b00 from reset release -> axis_ready=2'b11 after exactly 101 cycles; a 10-cycle home_n[0] high glitch in SETTLE delays ready by 10 cycles only.
REQ-034 Both ready, m_busy=0, rec_valid with pos 16'h8000/16'h0040 -> next cycle set_pos = 1024+1024=2048 / 1026, set_pos_valid=2'b11 for one cycle.
REQ-035 m_busy[0]=1, two rec_valid (0x0400 then 0x0800) -> nothing issued on axis 0; m_busy[0] falls -> single strobe with 1024+64=1088.
REQ-036 pos 16'hFFFF with OFFSET=65500 -> set_pos = (2047+65500) mod 65536 = 2011.
REQ-037 RUN, home_n[1] high 49 cycles -> stays ready; 50 cycles -> axis_ready[1]=0, pending cleared, set_pos[1] held, axis 0 unaffected.
REQ-038 vel_wr with 34 -> set_vel=34 next cycle; assert rst_n low mid-RUN -> all outputs at reset values, set_vel=136.
